// File: rtl/hyst_comparator_pkg.sv
// Shared types and helpers for the hysteresis comparator.
// Holds the filter state encoding and the width used for the extended-width arithmetic.
package comparator_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    PEND_HIGH = 2'd1,
    HIGH      = 2'd2,
    PEND_LOW  = 2'd3
  } hc_state_t;

  // Two guard bits let B +/- HYST be computed without wrapping in either mode.
  function automatic int ext_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/hyst_comparator_if.sv
// Sample/flag bundle for hyst_comparator: the source drives in_valid/A/B/is_signed,
// and the comparator drives the raw flags and the filtered output.
interface hyst_comparator_if #(
  parameter int WIDTH = 10
);
  // Valid-only handshake: a sample transfers on every clock edge where in_valid=1.
  // There is no ready; the comparator accepts one sample per cycle unconditionally.
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             flags_valid;
  logic             out;
  logic             rise;
  logic             fall;

  modport master (
    output in_valid, A, B, is_signed,
    input  gt, eq, lt, flags_valid, out, rise, fall
  );

  modport slave (
    input  in_valid, A, B, is_signed,
    output gt, eq, lt, flags_valid, out, rise, fall
  );
endinterface

// File: rtl/hyst_comparator_compare_core.sv
// Combinational compare of A against B and against the hysteresis band B +/- HYST.
// Operands are widened by two bits so out-of-range band edges simply never match.
module compare_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int HYST  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             above_upper,
  output logic             below_lower
);

  localparam int EW = ext_width(WIDTH);
  localparam logic signed [EW-1:0] HYST_X = EW'(HYST);

  logic signed [EW-1:0] a_x;
  logic signed [EW-1:0] b_x;
  logic signed [EW-1:0] upper;
  logic signed [EW-1:0] lower;

  always_comb begin
    a_x = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_x = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    upper = b_x + HYST_X;
    lower = b_x - HYST_X;
    gt = (a_x > b_x);
    eq = (a_x == b_x);
    lt = (a_x < b_x);
    above_upper = (a_x > upper);
    below_lower = (a_x < lower);
  end

endmodule

// File: rtl/hyst_comparator.sv
// Registered comparator with a hysteresis + persistence filter on the output.
// out switches only after PERSIST consecutive valid samples beyond the band edge.
module hyst_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int HYST    = 4,
  parameter int PERSIST = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  hyst_comparator_if.slave               bus,
  output hc_state_t                      dbg_state,
  output logic [$clog2(PERSIST+1)-1:0]   dbg_cnt
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] PERSIST_C = CW'(PERSIST);

  logic raw_gt, raw_eq, raw_lt, above_upper, below_lower;

  compare_core #(
    .WIDTH (WIDTH),
    .HYST  (HYST)
  ) u_core (
    .a           (bus.A),
    .b           (bus.B),
    .is_signed   (bus.is_signed),
    .gt          (raw_gt),
    .eq          (raw_eq),
    .lt          (raw_lt),
    .above_upper (above_upper),
    .below_lower (below_lower)
  );

  hc_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           gt_q, gt_d;
  logic           eq_q, eq_d;
  logic           lt_q, lt_d;
  logic           flags_valid_q, flags_valid_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOW;
      cnt_q         <= '0;
      gt_q          <= 1'b0;
      eq_q          <= 1'b0;
      lt_q          <= 1'b0;
      flags_valid_q <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gt_q          <= gt_d;
      eq_q          <= eq_d;
      lt_q          <= lt_d;
      flags_valid_q <= flags_valid_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gt_d          = gt_q;
    eq_d          = eq_q;
    lt_d          = lt_q;
    flags_valid_d = 1'b0;
    rise_d        = 1'b0;
    fall_d        = 1'b0;

    if (bus.in_valid) begin
      gt_d          = raw_gt;
      eq_d          = raw_eq;
      lt_d          = raw_lt;
      flags_valid_d = 1'b1;

      case (state_q)
        LOW: begin
          if (above_upper) begin
            if (PERSIST == 1) begin
              state_d = HIGH;
              cnt_d   = '0;
              rise_d  = 1'b1;
            end else begin
              state_d = PEND_HIGH;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_HIGH: begin
          if (!above_upper) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == PERSIST_C) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HIGH: begin
          if (below_lower) begin
            if (PERSIST == 1) begin
              state_d = LOW;
              cnt_d   = '0;
              fall_d  = 1'b1;
            end else begin
              state_d = PEND_LOW;
              cnt_d   = CW'(1);
            end
          end
        end
        PEND_LOW: begin
          if (!below_lower) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q + CW'(1) == PERSIST_C) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A pending state keeps the previous out value until the switch is confirmed.
  assign bus.out         = (state_q == HIGH) || (state_q == PEND_LOW);
  assign bus.gt          = gt_q;
  assign bus.eq          = eq_q;
  assign bus.lt          = lt_q;
  assign bus.flags_valid = flags_valid_q;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign dbg_state       = state_q;
  assign dbg_cnt         = cnt_q;

endmodule

// File: tb/tb_hyst_comparator.sv
// Self-checking bench for hyst_comparator: directed scenarios followed by random samples,
// each cycle compared against a value-level model of the hysteresis/persistence filter.
module tb_hyst_comparator;
  import comparator_pkg::*;

  localparam int WIDTH   = 10;
  localparam int HYST    = 4;
  localparam int PERSIST = 3;
  localparam int CW      = $clog2(PERSIST + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  hc_state_t     dbg_state;
  logic [CW-1:0] dbg_cnt;

  hyst_comparator_if #(.WIDTH(WIDTH)) bus ();

  hyst_comparator #(
    .WIDTH   (WIDTH),
    .HYST    (HYST),
    .PERSIST (PERSIST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // out level, length of the current run of qualifying samples, held raw flags.
  bit m_out;
  int m_run;
  bit m_gt, m_eq, m_lt;

  function automatic int to_int(input logic [WIDTH-1:0] v, input bit s);
    if (s && v[WIDTH-1]) return int'(v) - (1 << WIDTH);
    return int'(v);
  endfunction

  task automatic model_reset();
    m_out = 0;
    m_run = 0;
    m_gt  = 0;
    m_eq  = 0;
    m_lt  = 0;
  endtask

  task automatic model_step(input bit v, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input bit s);
    int ai, bi;
    bit r, f;
    r = 0;
    f = 0;
    if (v) begin
      ai = to_int(a, s);
      bi = to_int(b, s);
      m_gt = (ai > bi);
      m_eq = (ai == bi);
      m_lt = (ai < bi);
      if (!m_out) begin
        m_run = (ai > bi + HYST) ? m_run + 1 : 0;
        if (m_run == PERSIST) begin
          m_out = 1;
          m_run = 0;
          r = 1;
        end
      end else begin
        m_run = (ai < bi - HYST) ? m_run + 1 : 0;
        if (m_run == PERSIST) begin
          m_out = 0;
          m_run = 0;
          f = 1;
        end
      end
    end
    exp_q.push_back({m_gt, m_eq, m_lt, v, m_out, r, f});
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] e;
    e = exp_q.pop_front();
    check({tag, ".gt"},   32'(bus.gt),          32'(e[6]));
    check({tag, ".eq"},   32'(bus.eq),          32'(e[5]));
    check({tag, ".lt"},   32'(bus.lt),          32'(e[4]));
    check({tag, ".fv"},   32'(bus.flags_valid), 32'(e[3]));
    check({tag, ".out"},  32'(bus.out),         32'(e[2]));
    check({tag, ".rise"}, 32'(bus.rise),        32'(e[1]));
    check({tag, ".fall"}, 32'(bus.fall),        32'(e[0]));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input string tag, input bit v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit s);
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.is_signed = s;
    model_step(v, a, b, s);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive_n(input string tag, input int n, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit s);
    for (int i = 0; i < n; i++) drive(tag, 1'b1, a, b, s);
  endtask

  task automatic drive_idle(input string tag);
    drive(tag, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
  endtask

  // Reset is held with a valid all-ones sample present to prove reset wins.
  task automatic do_reset(input int n);
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 10'h3FF;
    bus.B         = 10'h000;
    bus.is_signed = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(7'b0);
      check_outputs("reset");
      check("reset.state", 32'(dbg_state), 32'(LOW));
      check("reset.cnt", 32'(dbg_cnt), 32'd0);
    end
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] rb, ra;
    bit rs;
    int off;

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.is_signed = 1'b0;
    model_reset();

    do_reset(2);
    drive_idle("post_reset_idle");

    // mode
    drive("mode_u", 1'b1, 10'h3FF, 10'h000, 1'b0);
    check("mode_u_gt", 32'(bus.gt), 32'd1);
    drive("mode_s", 1'b1, 10'h3FF, 10'h000, 1'b1);
    check("mode_s_lt", 32'(bus.lt), 32'd1);
    drive("mode_eq", 1'b1, 10'd7, 10'd7, 1'b0);
    check("mode_eq_eq", 32'(bus.eq), 32'd1);
    do_reset(1);

    // hysteresis around B=500
    drive_n("hyst_504", 5, 10'd504, 10'd500, 1'b0);
    check("hyst_504_out", 32'(bus.out), 32'd0);
    drive_n("hyst_505", 2, 10'd505, 10'd500, 1'b0);
    check("hyst_505_norise", 32'(bus.rise), 32'd0);
    drive("hyst_505_3rd", 1'b1, 10'd505, 10'd500, 1'b0);
    check("hyst_rise", 32'(bus.rise), 32'd1);
    check("hyst_out_hi", 32'(bus.out), 32'd1);
    drive_idle("hyst_rise_once");
    check("hyst_rise_once", 32'(bus.rise), 32'd0);
    drive_n("hyst_496", 3, 10'd496, 10'd500, 1'b0);
    check("hyst_496_out", 32'(bus.out), 32'd1);
    drive_n("hyst_495", 3, 10'd495, 10'd500, 1'b0);
    check("hyst_fall", 32'(bus.fall), 32'd1);
    check("hyst_out_lo", 32'(bus.out), 32'd0);

    // persistence interrupt, then gaps
    drive_n("intr_a", 2, 10'd505, 10'd500, 1'b0);
    drive("intr_b", 1'b1, 10'd500, 10'd500, 1'b0);
    drive_n("intr_c", 2, 10'd505, 10'd500, 1'b0);
    check("intr_norise", 32'(bus.out), 32'd0);
    drive("intr_d", 1'b1, 10'd505, 10'd500, 1'b0);
    check("intr_rise", 32'(bus.rise), 32'd1);
    drive_n("intr_back", 3, 10'd495, 10'd500, 1'b0);
    drive("gap_1", 1'b1, 10'd505, 10'd500, 1'b0);
    drive_idle("gap_i1");
    drive("gap_2", 1'b1, 10'd505, 10'd500, 1'b0);
    drive_idle("gap_i2");
    check("gap_hold_gt", 32'(bus.gt), 32'd1);
    drive("gap_3", 1'b1, 10'd505, 10'd500, 1'b0);
    check("gap_rise", 32'(bus.rise), 32'd1);

    // unreachable band edges
    do_reset(1);
    drive_n("bnd_u", 10, 10'd1023, 10'd1020, 1'b0);
    check("bnd_u_out", 32'(bus.out), 32'd0);
    drive_n("bnd_s_up", 3, 10'd0, 10'h202, 1'b1);
    check("bnd_s_high", 32'(bus.out), 32'd1);
    drive_n("bnd_s", 10, 10'h200, 10'h202, 1'b1);
    check("bnd_s_out", 32'(bus.out), 32'd1);

    // reset while pending
    do_reset(1);
    drive_n("rmid_pre", 2, 10'd505, 10'd500, 1'b0);
    check("rmid_cnt2", 32'(dbg_cnt), 32'd2);
    do_reset(1);
    drive_n("rmid_post", 2, 10'd505, 10'd500, 1'b0);
    check("rmid_norise", 32'(bus.out), 32'd0);
    drive("rmid_3rd", 1'b1, 10'd505, 10'd500, 1'b0);
    check("rmid_rise", 32'(bus.rise), 32'd1);

    // random samples near a slowly changing threshold
    rb = WIDTH'($urandom);
    rs = 1'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 1) begin
        do_reset(1);
      end else begin
        if ($urandom_range(0, 99) < 4) rb = WIDTH'($urandom);
        if ($urandom_range(0, 99) < 3) rs = ~rs;
        off = int'($urandom_range(0, 18)) - 9;
        ra  = WIDTH'(int'(rb) + off);
        if ($urandom_range(0, 99) < 80) drive("rand", 1'b1, ra, rb, rs);
        else drive_idle("rand_idle");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
